// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester round-robin arbiter with a registered one-hot grant.
// A grant stays with its owner while that owner keeps requesting. If MAX_HOLD
// is nonzero, the owner is forced to hand off after MAX_HOLD consecutive cycles
// whenever another requester is waiting.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   req          request vector, bit i = requester i
//   grant        registered one-hot grant, all-zero when idle
//   grant_idx    index of the current owner, 0 when idle
//   grant_valid  high when any grant bit is set
//   preempt      one-cycle pulse in the first grant cycle after a forced handoff
module rr_arbiter_n #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               preempt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_t              state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [IDX_W-1:0]    idx_n;
  logic                preempt_n;

  logic [NUM_REQ-1:0]  cand;
  logic                hi_found, lo_found, win_found;
  logic [IDX_W-1:0]    hi_idx, lo_idx, win_idx;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (32'(i) == 32'(NUM_REQ - 1)) return '0;
    else return i + 1'b1;
  endfunction

  // While busy, ptr always equals owner+1, so searching from ptr with the
  // owner masked out is the same as searching from owner+1 excluding owner.
  always_comb begin
    cand     = (state == BUSY) ? (req & ~grant) : req;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (cand[j]) begin
        if (j >= 32'(ptr)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDX_W'(j);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(j);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    grant_n   = grant;
    idx_n     = grant_idx;
    preempt_n = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = BUSY;
          grant_n = NUM_REQ'(1) << win_idx;
          idx_n   = win_idx;
          hold_n  = HOLD_W'(1);
          ptr_n   = wrap_inc(win_idx);
        end else begin
          grant_n = '0;
          idx_n   = '0;
          hold_n  = '0;
        end
      end
      BUSY: begin
        if ((req & grant) == '0) begin
          state_n = IDLE;
          grant_n = '0;
          idx_n   = '0;
          hold_n  = '0;
        end else if (MAX_HOLD == 0) begin
          hold_n = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
        end else if (hold_cnt < HOLD_LIM) begin
          hold_n = hold_cnt + 1'b1;
        end else if (win_found) begin
          grant_n   = NUM_REQ'(1) << win_idx;
          idx_n     = win_idx;
          hold_n    = HOLD_W'(1);
          ptr_n     = wrap_inc(win_idx);
          preempt_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        idx_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      preempt   <= preempt_n;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = '0;

  logic [3:0] g0, g4;
  logic [1:0] i0, i4;
  logic       v0, v4, p0, p4;

  int checks = 0;
  int errors = 0;

  rr_arbiter_n #(.NUM_REQ(4), .IDX_W(2), .MAX_HOLD(0), .HOLD_W(8)) dut0 (
    .clock(clock), .reset(reset), .req(req),
    .grant(g0), .grant_idx(i0), .grant_valid(v0), .preempt(p0)
  );

  rr_arbiter_n #(.NUM_REQ(4), .IDX_W(2), .MAX_HOLD(4), .HOLD_W(8)) dut4 (
    .clock(clock), .reset(reset), .req(req),
    .grant(g4), .grant_idx(i4), .grant_valid(v4), .preempt(p4)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    step();
    step();
    checks++; if (g0 !== 4'b0000) begin errors++; $display("FAIL reset_grant0: got %b exp 0000", g0); end
    checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL reset_grant4: got %b exp 0000", g4); end
    checks++; if (i0 !== 2'd0) begin errors++; $display("FAIL reset_idx0: got %0d exp 0", i0); end
    checks++; if (v0 !== 1'b0 || v4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b exp 0/0", v0, v4); end
    checks++; if (p0 !== 1'b0 || p4 !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b/%b exp 0/0", p0, p4); end
    reset = 1'b0;
    req   = 4'b0000;
    step();
    checks++; if (g0 !== 4'b0000 || g4 !== 4'b0000) begin errors++; $display("FAIL idle_grant: got %b/%b exp 0000", g0, g4); end
  endtask

  task automatic test_single();
    req = 4'b0100;
    step();
    checks++; if (g0 !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b exp 0100", g0); end
    checks++; if (i0 !== 2'd2) begin errors++; $display("FAIL single_idx: got %0d exp 2", i0); end
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", v0); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (g0 !== 4'b0100 || g4 !== 4'b0100) begin errors++; $display("FAIL single_hold%0d: got %b/%b exp 0100", k, g0, g4); end
      checks++; if (p4 !== 1'b0) begin errors++; $display("FAIL single_preempt%0d: got %b exp 0", k, p4); end
    end
    req = 4'b0000;
    step();
    checks++; if (g0 !== 4'b0000 || v0 !== 1'b0) begin errors++; $display("FAIL single_release: got %b v=%b exp 0000 v=0", g0, v0); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      req = 4'b1111;
      step();
      checks++; if (g0 !== exp_g || g4 !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b/%b exp %b", k, g0, g4, exp_g); end
      checks++; if (i0 !== 2'(k % 4)) begin errors++; $display("FAIL rr_idx%0d: got %0d exp %0d", k, i0, k % 4); end
      req = 4'b1111 & ~exp_g;
      step();
      checks++; if (g0 !== 4'b0000 || g4 !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b/%b exp 0000", k, g0, g4); end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1000;
    step();
    checks++; if (g0 !== 4'b1000 || i0 !== 2'd3) begin errors++; $display("FAIL wrap_owner3: got %b idx %0d exp 1000 idx 3", g0, i0); end
    req = 4'b0001;
    step();
    checks++; if (g0 !== 4'b0000) begin errors++; $display("FAIL wrap_gap: got %b exp 0000", g0); end
    req = 4'b1001;
    step();
    checks++; if (g0 !== 4'b0001 || i0 !== 2'd0) begin errors++; $display("FAIL wrap_grant: got %b idx %0d exp 0001 idx 0", g0, i0); end
  endtask

  task automatic test_forced_handoff();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0001;
    step();
    checks++; if (g4 !== 4'b0001 || p4 !== 1'b0) begin errors++; $display("FAIL force_c1: got %b p=%b exp 0001 p=0", g4, p4); end
    req = 4'b0101;
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++; if (g4 !== 4'b0001 || p4 !== 1'b0) begin errors++; $display("FAIL force_c%0d: got %b p=%b exp 0001 p=0", c, g4, p4); end
    end
    step();
    checks++; if (g4 !== 4'b0100 || i4 !== 2'd2) begin errors++; $display("FAIL force_handoff: got %b idx %0d exp 0100 idx 2", g4, i4); end
    checks++; if (p4 !== 1'b1) begin errors++; $display("FAIL force_preempt: got %b exp 1", p4); end
    checks++; if (g0 !== 4'b0001 || p0 !== 1'b0) begin errors++; $display("FAIL force_unlimited: got %b p=%b exp 0001 p=0", g0, p0); end
    step();
    checks++; if (g4 !== 4'b0100 || p4 !== 1'b0) begin errors++; $display("FAIL force_after: got %b p=%b exp 0100 p=0", g4, p4); end
  endtask

  task automatic test_hold_alone();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (g4 !== 4'b0001 || p4 !== 1'b0) begin errors++; $display("FAIL alone_c%0d: got %b p=%b exp 0001 p=0", k, g4, p4); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0010;
    step();
    step();
    checks++; if (g0 !== 4'b0010 || g4 !== 4'b0010) begin errors++; $display("FAIL mid_busy: got %b/%b exp 0010", g0, g4); end
    reset = 1'b1;
    step();
    checks++; if (g0 !== 4'b0000 || g4 !== 4'b0000 || v0 !== 1'b0) begin errors++; $display("FAIL mid_reset: got %b/%b v=%b exp 0000 v=0", g0, g4, v0); end
    reset = 1'b0;
    req = 4'b0011;
    step();
    checks++; if (g0 !== 4'b0001 || g4 !== 4'b0001 || i0 !== 2'd0) begin errors++; $display("FAIL mid_ptr: got %b/%b idx %0d exp 0001 idx 0", g0, g4, i0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_forced_handoff();
    test_hold_alone();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
